// File: rtl/mem_access_sequencer.sv
// rtl/mem_access_sequencer.sv - single-port memory sequencer arbitrating instruction fetch and data requests
module mem_access_sequencer (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    input  logic        i_d_req,
    input  logic        i_d_we,
    input  logic [31:0] i_d_addr,
    input  logic [31:0] i_d_wdata,
    output logic        o_if_ack,
    output logic [31:0] o_if_rdata,
    output logic        o_d_ack,
    output logic [31:0] o_d_rdata,
    output logic        o_d_err,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic        o_mem_wr,
    input  logic [31:0] i_mem_rdata,
    output logic        o_busy
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WAIT, S_RESP} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_streak;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_we;
    logic        r_is_data;
    logic        r_err;
    logic [31:0] r_if_rdata;
    logic [31:0] r_d_rdata;

    logic w_any_req;
    logic w_fetch_win;
    logic w_misaligned;

    // Data normally wins; a fetch starved by three data grants in a row gets the next slot.
    assign w_any_req    = i_if_req | i_d_req;
    assign w_fetch_win  = i_if_req & (~i_d_req | (r_streak == 2'd3));
    assign w_misaligned = (i_d_addr[1:0] != 2'b00);

    always_comb begin
        w_next   = r_state;
        o_mem_wr = 1'b0;
        o_if_ack = 1'b0;
        o_d_ack  = 1'b0;
        o_d_err  = 1'b0;
        o_busy   = 1'b1;
        case (r_state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (w_any_req) begin
                    if (w_fetch_win)       w_next = S_ADDR;
                    else if (w_misaligned) w_next = S_RESP;
                    else                   w_next = S_ADDR;
                end
            end
            S_ADDR: begin
                o_mem_wr = r_we;
                w_next   = r_we ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                w_next = S_RESP;
            end
            S_RESP: begin
                o_if_ack = ~r_is_data;
                o_d_ack  = r_is_data;
                o_d_err  = r_err;
                w_next   = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_streak   <= 2'd0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_we       <= 1'b0;
            r_is_data  <= 1'b0;
            r_err      <= 1'b0;
            r_if_rdata <= 32'd0;
            r_d_rdata  <= 32'd0;
        end else begin
            r_state <= w_next;
            if ((r_state == S_IDLE) && w_any_req) begin
                if (w_fetch_win) begin
                    r_addr    <= i_if_addr;
                    r_we      <= 1'b0;
                    r_is_data <= 1'b0;
                    r_err     <= 1'b0;
                    r_streak  <= 2'd0;
                end else begin
                    r_addr    <= i_d_addr;
                    r_we      <= i_d_we;
                    r_wdata   <= i_d_wdata;
                    r_is_data <= 1'b1;
                    r_err     <= w_misaligned;
                    if (i_if_req && (r_streak != 2'd3))
                        r_streak <= r_streak + 2'd1;
                end
            end
            // Memory data is valid during WAIT; steer it into the requester's own register.
            if (r_state == S_WAIT) begin
                if (r_is_data) r_d_rdata  <= i_mem_rdata;
                else           r_if_rdata <= i_mem_rdata;
            end
        end
    end

    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;
    assign o_if_rdata  = r_if_rdata;
    assign o_d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// tb/tb_mem_access_sequencer.sv - self-checking bench for mem_access_sequencer
module tb_mem_access_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic        if_ack, d_ack, d_err, mem_wr, busy;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_access_sequencer dut (
        .i_clock    (clk),
        .i_reset    (reset),
        .i_if_req   (if_req),
        .i_if_addr  (if_addr),
        .i_d_req    (d_req),
        .i_d_we     (d_we),
        .i_d_addr   (d_addr),
        .i_d_wdata  (d_wdata),
        .o_if_ack   (if_ack),
        .o_if_rdata (if_rdata),
        .o_d_ack    (d_ack),
        .o_d_rdata  (d_rdata),
        .o_d_err    (d_err),
        .o_mem_addr (mem_addr),
        .o_mem_wdata(mem_wdata),
        .o_mem_wr   (mem_wr),
        .i_mem_rdata(mem_rdata),
        .o_busy     (busy)
    );

    function automatic logic [31:0] def_word(input int idx);
        return 32'hA000_0005 | (32'(idx) << 4);
    endfunction

    // External memory: registered read, word-indexed by addr[9:2]
    logic [31:0] mem [0:255];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = def_word(i);
        mem[4] = 32'hDEADBEEF;
    end
    always @(posedge clk) begin
        mem_rdata <= mem[mem_addr[9:2]];
        if (mem_wr) mem[mem_addr[9:2]] <= mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference model: each grant becomes a fixed-length transaction
    localparam int K_F = 0, K_L = 1, K_S = 2, K_M = 3;
    logic [31:0] sh [0:255];
    bit          m_valid = 0;
    bit          m_active;
    int          m_phase, m_lat, m_kind, m_streak;
    logic [31:0] m_addr, m_wdata, m_if_rd, m_d_rd;

    initial begin
        bit ack_now, wr_now;
        for (int i = 0; i < 256; i++) sh[i] = def_word(i);
        sh[4] = 32'hDEADBEEF;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                ack_now = m_active && (m_phase == m_lat);
                wr_now  = m_active && (m_kind == K_S) && (m_phase == 1);
                if (ack_now && m_kind == K_F) m_if_rd = sh[m_addr[9:2]];
                if (ack_now && m_kind == K_L) m_d_rd  = sh[m_addr[9:2]];
                chk("model busy",     busy,     m_active);
                chk("model mem_wr",   mem_wr,   wr_now);
                if (wr_now) chk("model mem_wdata", mem_wdata, m_wdata);
                chk("model mem_addr", mem_addr, m_addr);
                chk("model if_ack",   if_ack,   ack_now && m_kind == K_F);
                chk("model d_ack",    d_ack,    ack_now && m_kind != K_F);
                chk("model d_err",    d_err,    ack_now && m_kind == K_M);
                chk("model if_rdata", if_rdata, m_if_rd);
                chk("model d_rdata",  d_rdata,  m_d_rd);
            end
            if (m_valid && m_active && m_kind == K_S && m_phase == 1)
                sh[m_addr[9:2]] = m_wdata;
            if (reset) begin
                m_valid = 1; m_active = 0; m_phase = 0; m_lat = 0; m_kind = K_F;
                m_streak = 0; m_addr = 0; m_wdata = 0; m_if_rd = 0; m_d_rd = 0;
            end else if (m_valid) begin
                if (m_active) begin
                    if (m_phase == m_lat) m_active = 0;
                    else m_phase++;
                end else if (if_req || d_req) begin
                    m_active = 1;
                    m_phase  = 1;
                    if (if_req && (!d_req || m_streak == 3)) begin
                        m_kind = K_F; m_lat = 3; m_addr = if_addr; m_streak = 0;
                    end else begin
                        m_addr  = d_addr;
                        m_wdata = d_wdata;
                        if (if_req && m_streak < 3) m_streak++;
                        if (d_addr[1:0] != 2'b00) begin m_kind = K_M; m_lat = 1; end
                        else if (d_we)            begin m_kind = K_S; m_lat = 2; end
                        else                      begin m_kind = K_L; m_lat = 3; end
                    end
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Issues one request at cycle 0 and waits (bounded) for its ack.
    task automatic do_txn(input bit f, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          output int ack_cyc, output logic [31:0] rdata, output logic err,
                          output int wr_cnt, output logic [31:0] wr_addr, output logic [31:0] wr_data);
        ack_cyc = -1; rdata = 'x; err = 'x; wr_cnt = 0; wr_addr = 'x; wr_data = 'x;
        if (f) begin if_req = 1; if_addr = addr; end
        else   begin d_req = 1; d_we = we; d_addr = addr; d_wdata = wdata; end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (mem_wr) begin wr_cnt++; wr_addr = mem_addr; wr_data = mem_wdata; end
            if (f ? if_ack : d_ack) begin
                ack_cyc = c;
                rdata   = f ? if_rdata : d_rdata;
                err     = d_err;
                break;
            end
        end
        next_cycle();
        if_req = 0; d_req = 0;
    endtask

    initial begin
        int          ac, wc;
        logic [31:0] rd, wa, wd;
        logic        er;
        string       order;
        int          nack;

        reset = 1; if_req = 0; d_req = 0; d_we = 0;
        if_addr = 0; d_addr = 0; d_wdata = 0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset mem_wr", mem_wr, 0);
        chk("reset if_ack", if_ack, 0);
        chk("reset d_ack", d_ack, 0);
        chk("reset d_err", d_err, 0);
        chk("reset mem_addr", mem_addr, 0);
        chk("reset if_rdata", if_rdata, 0);
        chk("reset d_rdata", d_rdata, 0);
        next_cycle();
        reset = 0;

        do_txn(1, 0, 32'h10, 0, ac, rd, er, wc, wa, wd);
        chk("fetch ack cycle", ac, 3);
        chk("fetch rdata", rd, 32'hDEADBEEF);
        chk("fetch no write", wc, 0);

        do_txn(0, 1, 32'h20, 32'h12345678, ac, rd, er, wc, wa, wd);
        chk("store ack cycle", ac, 2);
        chk("store write count", wc, 1);
        chk("store mem_addr", wa, 32'h20);
        chk("store mem_wdata", wd, 32'h12345678);

        do_txn(0, 1, 32'h44, 32'hCAFEF00D, ac, rd, er, wc, wa, wd);
        chk("store2 ack cycle", ac, 2);
        do_txn(0, 0, 32'h44, 0, ac, rd, er, wc, wa, wd);
        chk("load ack cycle", ac, 3);
        chk("load rdata", rd, 32'hCAFEF00D);
        chk("load err", er, 0);

        do_txn(0, 0, 32'h22, 0, ac, rd, er, wc, wa, wd);
        chk("misaligned load ack cycle", ac, 1);
        chk("misaligned load err", er, 1);
        chk("misaligned load no write", wc, 0);
        chk("misaligned load rdata held", rd, 32'hCAFEF00D);

        do_txn(0, 1, 32'h45, 32'h0000DEAD, ac, rd, er, wc, wa, wd);
        chk("misaligned store ack cycle", ac, 1);
        chk("misaligned store err", er, 1);
        chk("misaligned store no write", wc, 0);
        do_txn(0, 0, 32'h44, 0, ac, rd, er, wc, wa, wd);
        chk("reload after misaligned store", rd, 32'hCAFEF00D);

        // Address change after grant must not disturb the in-flight fetch
        if_req = 1; if_addr = 32'h30;
        @(negedge clk);
        next_cycle();
        if_addr = 32'h40;
        @(negedge clk);
        chk("latched addr ADDR", mem_addr, 32'h30);
        @(negedge clk);
        chk("latched addr WAIT", mem_addr, 32'h30);
        @(negedge clk);
        chk("latched fetch ack", if_ack, 1);
        chk("latched fetch rdata", if_rdata, def_word(12));
        next_cycle();
        if_req = 0;

        // Reset during WAIT of a fetch
        if_req = 1; if_addr = 32'h10;
        @(negedge clk);
        @(negedge clk);
        next_cycle();
        reset = 1;
        @(negedge clk);
        chk("abort fetch no ack in WAIT", if_ack, 0);
        next_cycle();
        reset = 0; if_req = 0;
        @(negedge clk);
        chk("abort busy", busy, 0);
        chk("abort no ack", if_ack, 0);
        chk("abort rdata cleared", if_rdata, 0);
        next_cycle();
        do_txn(1, 0, 32'h10, 0, ac, rd, er, wc, wa, wd);
        chk("fetch after abort ack cycle", ac, 3);
        chk("fetch after abort rdata", rd, 32'hDEADBEEF);

        // Reset during ADDR of a store
        d_req = 1; d_we = 1; d_addr = 32'h300; d_wdata = 32'h0BADF00D;
        @(negedge clk);
        next_cycle();
        reset = 1;
        @(negedge clk);
        chk("store ADDR strobe before reset edge", mem_wr, 1);
        next_cycle();
        reset = 0; d_req = 0;
        @(negedge clk);
        chk("store abort mem_wr", mem_wr, 0);
        chk("store abort d_ack", d_ack, 0);
        chk("store abort busy", busy, 0);
        next_cycle();

        // Continuous contention: grant order from a cleared streak
        reset = 1;
        next_cycle();
        reset = 0;
        if_req = 1; if_addr = 32'h200;
        d_req = 1; d_we = 0; d_addr = 32'h100;
        order = "";
        nack = 0;
        for (int c = 0; c < 80 && nack < 8; c++) begin
            @(negedge clk);
            if (d_ack)  begin order = {order, "D"}; nack++; end
            if (if_ack) begin order = {order, "F"}; nack++; end
        end
        next_cycle();
        if_req = 0; d_req = 0;
        n_tests++;
        if (order != "DDDFDDDF") begin
            n_fail++;
            $display("FAIL grant order: got %s expected DDDFDDDF", order);
        end
        chk("contention last fetch rdata", if_rdata, def_word(128));
        chk("contention last load rdata", d_rdata, def_word(64));

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_sequencer.md
MEM_ACCESS_SEQUENCER -- requirements
Module: mem_access_sequencer

Interface
REQ-001 SHALL have ports: clock  in  1  single clock, all state changes on posedge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high.
REQ-003 SHALL have ports: if_req  in  1  instruction-fetch read request; if_addr  in  32  fetch word address.
REQ-004 SHALL have ports: d_req  in  1  data request; d_we  in  1  1 = store, 0 = load; d_addr  in  32; d_wdata  in  32.
REQ-005 SHALL have ports: if_ack  out  1  fetch done pulse; if_rdata  out  32  fetched word.
REQ-006 SHALL have ports: d_ack  out  1  data done pulse; d_rdata  out  32  loaded word; d_err  out  1  misaligned flag, valid with d_ack.
REQ-007 SHALL have ports: mem_addr  out  32; mem_wdata  out  32; mem_wr  out  1  memory write strobe; mem_rdata  in  32  memory read data, one-cycle registered latency.
REQ-008 SHALL have port busy  out  1  high in every state except IDLE.

Function
REQ-009 SHALL implement FSM states IDLE, ADDR, WAIT, RESP.
REQ-010 IDLE: if any request is pending, SHALL grant one requester, latch its addr, we and wdata, and go to ADDR; otherwise SHALL stay in IDLE.
REQ-011 Arbitration: d_req SHALL win over if_req, unless streak counter = 3 and if_req is high, in which case fetch SHALL win.
REQ-012 Streak counter: 2-bit, SHALL increment (saturating at 3) on each data grant made while if_req is high, and SHALL clear on any fetch grant.
REQ-013 Data grant with d_addr[1:0] != 0: SHALL skip ADDR/WAIT, go directly to RESP with d_err=1, and SHALL NOT assert mem_wr.
REQ-014 ADDR: mem_addr SHALL equal the latched addr; mem_wr SHALL be 1 for exactly this cycle on a store grant; store SHALL then go to RESP, load/fetch SHALL go to WAIT.
REQ-015 WAIT: mem_addr SHALL be held and mem_wr SHALL be 0; mem_rdata SHALL be captured into the read register at the closing edge; next state SHALL be RESP.
REQ-016 RESP: the ack of the granted requester SHALL be 1 for exactly one cycle, with rdata (load/fetch) from the read register; next state SHALL be IDLE.
REQ-017 Latency: with the request high in IDLE at cycle 0, the read ack SHALL occur in cycle 3, the store ack in cycle 2, and the misaligned ack in cycle 1.
REQ-018 Requester SHALL hold req until ack and drop it in the cycle after ack; a req still high in IDLE SHALL be treated as a new transaction.
REQ-019 Changes to addr/wdata after grant SHALL NOT affect the in-flight transaction (latched values are used).
REQ-020 if_rdata/d_rdata SHALL hold their last value between acks; the non-granted ack SHALL stay 0.
REQ-021 mem_wdata SHALL equal the latched wdata; mem_addr in IDLE/RESP SHALL be the last latched addr.
REQ-022 Simultaneous if_req and d_req in IDLE SHALL result in exactly one grant per transaction; the loser SHALL remain pending with no ack.

Reset
REQ-023 Reset SHALL force IDLE, streak=0, mem_wr=0, if_ack=0, d_ack=0, d_err=0, busy=0, and clear all latched and read registers to 0.
REQ-024 Reset mid-transaction SHALL abort it without ack; a store aborted in ADDR SHALL have mem_wr=0 from the reset edge on.

Verification
REQ-025 Fetch if_addr=0x00000010, mem_rdata=0xDEADBEEF in WAIT -> if_ack in cycle 3, if_rdata=0xDEADBEEF, mem_wr never 1.
REQ-026 Store d_addr=0x20, d_wdata=0x12345678 -> mem_wr=1 for one cycle with mem_addr=0x20 and mem_wdata=0x12345678; d_ack in cycle 2.
REQ-027 if_req and d_req both held continuously, d_ack and d_req re-issued -> grant order D,D,D,F,D,D,D,F,...
REQ-028 Load d_addr=0x22 -> d_ack in cycle 1 with d_err=1, no mem_wr, d_rdata unchanged.
REQ-029 Reset asserted in the WAIT cycle of a fetch -> no if_ack, busy=0 next cycle, next fetch completes normally.
REQ-030 if_addr changed to 0x40 in the ADDR cycle of a fetch to 0x30 -> mem_addr stays 0x30 through WAIT.
